// File: rtl/aes_dec_pkg.sv
// Shared definitions for the AES decryption datapath stages.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package aes_dec_pkg;

  localparam int AES_BLK_W  = 128;
  localparam int AES_BYTE_W = 8;
  localparam int AES_NBYTES = AES_BLK_W / AES_BYTE_W;
  localparam int AES_IDX_W  = $clog2(AES_NBYTES);

  // Iterative stage control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } dec_st_e;

  // Counter width for a stage that takes ncyc cycles; never narrower than 1 bit.
  function automatic int cnt_width(input int ncyc);
    return (ncyc > 1) ? $clog2(ncyc) : 1;
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// AES inverse S-box (FIPS-197 InvSubBytes table), one byte in, one byte out.
// Latency: purely combinational.
// Backpressure: none (no state).
// Ports: i_Din - input byte; o_Dout - inverse-substituted byte.
module inv_sbox (
  input  logic [7:0] i_Din,
  output logic [7:0] o_Dout
);

  always_comb begin
    o_Dout = 8'h00;
    case (i_Din)
      8'h00: o_Dout = 8'h52; 8'h01: o_Dout = 8'h09; 8'h02: o_Dout = 8'h6a; 8'h03: o_Dout = 8'hd5; 8'h04: o_Dout = 8'h30; 8'h05: o_Dout = 8'h36; 8'h06: o_Dout = 8'ha5; 8'h07: o_Dout = 8'h38;
      8'h08: o_Dout = 8'hbf; 8'h09: o_Dout = 8'h40; 8'h0a: o_Dout = 8'ha3; 8'h0b: o_Dout = 8'h9e; 8'h0c: o_Dout = 8'h81; 8'h0d: o_Dout = 8'hf3; 8'h0e: o_Dout = 8'hd7; 8'h0f: o_Dout = 8'hfb;
      8'h10: o_Dout = 8'h7c; 8'h11: o_Dout = 8'he3; 8'h12: o_Dout = 8'h39; 8'h13: o_Dout = 8'h82; 8'h14: o_Dout = 8'h9b; 8'h15: o_Dout = 8'h2f; 8'h16: o_Dout = 8'hff; 8'h17: o_Dout = 8'h87;
      8'h18: o_Dout = 8'h34; 8'h19: o_Dout = 8'h8e; 8'h1a: o_Dout = 8'h43; 8'h1b: o_Dout = 8'h44; 8'h1c: o_Dout = 8'hc4; 8'h1d: o_Dout = 8'hde; 8'h1e: o_Dout = 8'he9; 8'h1f: o_Dout = 8'hcb;
      8'h20: o_Dout = 8'h54; 8'h21: o_Dout = 8'h7b; 8'h22: o_Dout = 8'h94; 8'h23: o_Dout = 8'h32; 8'h24: o_Dout = 8'ha6; 8'h25: o_Dout = 8'hc2; 8'h26: o_Dout = 8'h23; 8'h27: o_Dout = 8'h3d;
      8'h28: o_Dout = 8'hee; 8'h29: o_Dout = 8'h4c; 8'h2a: o_Dout = 8'h95; 8'h2b: o_Dout = 8'h0b; 8'h2c: o_Dout = 8'h42; 8'h2d: o_Dout = 8'hfa; 8'h2e: o_Dout = 8'hc3; 8'h2f: o_Dout = 8'h4e;
      8'h30: o_Dout = 8'h08; 8'h31: o_Dout = 8'h2e; 8'h32: o_Dout = 8'ha1; 8'h33: o_Dout = 8'h66; 8'h34: o_Dout = 8'h28; 8'h35: o_Dout = 8'hd9; 8'h36: o_Dout = 8'h24; 8'h37: o_Dout = 8'hb2;
      8'h38: o_Dout = 8'h76; 8'h39: o_Dout = 8'h5b; 8'h3a: o_Dout = 8'ha2; 8'h3b: o_Dout = 8'h49; 8'h3c: o_Dout = 8'h6d; 8'h3d: o_Dout = 8'h8b; 8'h3e: o_Dout = 8'hd1; 8'h3f: o_Dout = 8'h25;
      8'h40: o_Dout = 8'h72; 8'h41: o_Dout = 8'hf8; 8'h42: o_Dout = 8'hf6; 8'h43: o_Dout = 8'h64; 8'h44: o_Dout = 8'h86; 8'h45: o_Dout = 8'h68; 8'h46: o_Dout = 8'h98; 8'h47: o_Dout = 8'h16;
      8'h48: o_Dout = 8'hd4; 8'h49: o_Dout = 8'ha4; 8'h4a: o_Dout = 8'h5c; 8'h4b: o_Dout = 8'hcc; 8'h4c: o_Dout = 8'h5d; 8'h4d: o_Dout = 8'h65; 8'h4e: o_Dout = 8'hb6; 8'h4f: o_Dout = 8'h92;
      8'h50: o_Dout = 8'h6c; 8'h51: o_Dout = 8'h70; 8'h52: o_Dout = 8'h48; 8'h53: o_Dout = 8'h50; 8'h54: o_Dout = 8'hfd; 8'h55: o_Dout = 8'hed; 8'h56: o_Dout = 8'hb9; 8'h57: o_Dout = 8'hda;
      8'h58: o_Dout = 8'h5e; 8'h59: o_Dout = 8'h15; 8'h5a: o_Dout = 8'h46; 8'h5b: o_Dout = 8'h57; 8'h5c: o_Dout = 8'ha7; 8'h5d: o_Dout = 8'h8d; 8'h5e: o_Dout = 8'h9d; 8'h5f: o_Dout = 8'h84;
      8'h60: o_Dout = 8'h90; 8'h61: o_Dout = 8'hd8; 8'h62: o_Dout = 8'hab; 8'h63: o_Dout = 8'h00; 8'h64: o_Dout = 8'h8c; 8'h65: o_Dout = 8'hbc; 8'h66: o_Dout = 8'hd3; 8'h67: o_Dout = 8'h0a;
      8'h68: o_Dout = 8'hf7; 8'h69: o_Dout = 8'he4; 8'h6a: o_Dout = 8'h58; 8'h6b: o_Dout = 8'h05; 8'h6c: o_Dout = 8'hb8; 8'h6d: o_Dout = 8'hb3; 8'h6e: o_Dout = 8'h45; 8'h6f: o_Dout = 8'h06;
      8'h70: o_Dout = 8'hd0; 8'h71: o_Dout = 8'h2c; 8'h72: o_Dout = 8'h1e; 8'h73: o_Dout = 8'h8f; 8'h74: o_Dout = 8'hca; 8'h75: o_Dout = 8'h3f; 8'h76: o_Dout = 8'h0f; 8'h77: o_Dout = 8'h02;
      8'h78: o_Dout = 8'hc1; 8'h79: o_Dout = 8'haf; 8'h7a: o_Dout = 8'hbd; 8'h7b: o_Dout = 8'h03; 8'h7c: o_Dout = 8'h01; 8'h7d: o_Dout = 8'h13; 8'h7e: o_Dout = 8'h8a; 8'h7f: o_Dout = 8'h6b;
      8'h80: o_Dout = 8'h3a; 8'h81: o_Dout = 8'h91; 8'h82: o_Dout = 8'h11; 8'h83: o_Dout = 8'h41; 8'h84: o_Dout = 8'h4f; 8'h85: o_Dout = 8'h67; 8'h86: o_Dout = 8'hdc; 8'h87: o_Dout = 8'hea;
      8'h88: o_Dout = 8'h97; 8'h89: o_Dout = 8'hf2; 8'h8a: o_Dout = 8'hcf; 8'h8b: o_Dout = 8'hce; 8'h8c: o_Dout = 8'hf0; 8'h8d: o_Dout = 8'hb4; 8'h8e: o_Dout = 8'he6; 8'h8f: o_Dout = 8'h73;
      8'h90: o_Dout = 8'h96; 8'h91: o_Dout = 8'hac; 8'h92: o_Dout = 8'h74; 8'h93: o_Dout = 8'h22; 8'h94: o_Dout = 8'he7; 8'h95: o_Dout = 8'had; 8'h96: o_Dout = 8'h35; 8'h97: o_Dout = 8'h85;
      8'h98: o_Dout = 8'he2; 8'h99: o_Dout = 8'hf9; 8'h9a: o_Dout = 8'h37; 8'h9b: o_Dout = 8'he8; 8'h9c: o_Dout = 8'h1c; 8'h9d: o_Dout = 8'h75; 8'h9e: o_Dout = 8'hdf; 8'h9f: o_Dout = 8'h6e;
      8'ha0: o_Dout = 8'h47; 8'ha1: o_Dout = 8'hf1; 8'ha2: o_Dout = 8'h1a; 8'ha3: o_Dout = 8'h71; 8'ha4: o_Dout = 8'h1d; 8'ha5: o_Dout = 8'h29; 8'ha6: o_Dout = 8'hc5; 8'ha7: o_Dout = 8'h89;
      8'ha8: o_Dout = 8'h6f; 8'ha9: o_Dout = 8'hb7; 8'haa: o_Dout = 8'h62; 8'hab: o_Dout = 8'h0e; 8'hac: o_Dout = 8'haa; 8'had: o_Dout = 8'h18; 8'hae: o_Dout = 8'hbe; 8'haf: o_Dout = 8'h1b;
      8'hb0: o_Dout = 8'hfc; 8'hb1: o_Dout = 8'h56; 8'hb2: o_Dout = 8'h3e; 8'hb3: o_Dout = 8'h4b; 8'hb4: o_Dout = 8'hc6; 8'hb5: o_Dout = 8'hd2; 8'hb6: o_Dout = 8'h79; 8'hb7: o_Dout = 8'h20;
      8'hb8: o_Dout = 8'h9a; 8'hb9: o_Dout = 8'hdb; 8'hba: o_Dout = 8'hc0; 8'hbb: o_Dout = 8'hfe; 8'hbc: o_Dout = 8'h78; 8'hbd: o_Dout = 8'hcd; 8'hbe: o_Dout = 8'h5a; 8'hbf: o_Dout = 8'hf4;
      8'hc0: o_Dout = 8'h1f; 8'hc1: o_Dout = 8'hdd; 8'hc2: o_Dout = 8'ha8; 8'hc3: o_Dout = 8'h33; 8'hc4: o_Dout = 8'h88; 8'hc5: o_Dout = 8'h07; 8'hc6: o_Dout = 8'hc7; 8'hc7: o_Dout = 8'h31;
      8'hc8: o_Dout = 8'hb1; 8'hc9: o_Dout = 8'h12; 8'hca: o_Dout = 8'h10; 8'hcb: o_Dout = 8'h59; 8'hcc: o_Dout = 8'h27; 8'hcd: o_Dout = 8'h80; 8'hce: o_Dout = 8'hec; 8'hcf: o_Dout = 8'h5f;
      8'hd0: o_Dout = 8'h60; 8'hd1: o_Dout = 8'h51; 8'hd2: o_Dout = 8'h7f; 8'hd3: o_Dout = 8'ha9; 8'hd4: o_Dout = 8'h19; 8'hd5: o_Dout = 8'hb5; 8'hd6: o_Dout = 8'h4a; 8'hd7: o_Dout = 8'h0d;
      8'hd8: o_Dout = 8'h2d; 8'hd9: o_Dout = 8'he5; 8'hda: o_Dout = 8'h7a; 8'hdb: o_Dout = 8'h9f; 8'hdc: o_Dout = 8'h93; 8'hdd: o_Dout = 8'hc9; 8'hde: o_Dout = 8'h9c; 8'hdf: o_Dout = 8'hef;
      8'he0: o_Dout = 8'ha0; 8'he1: o_Dout = 8'he0; 8'he2: o_Dout = 8'h3b; 8'he3: o_Dout = 8'h4d; 8'he4: o_Dout = 8'hae; 8'he5: o_Dout = 8'h2a; 8'he6: o_Dout = 8'hf5; 8'he7: o_Dout = 8'hb0;
      8'he8: o_Dout = 8'hc8; 8'he9: o_Dout = 8'heb; 8'hea: o_Dout = 8'hbb; 8'heb: o_Dout = 8'h3c; 8'hec: o_Dout = 8'h83; 8'hed: o_Dout = 8'h53; 8'hee: o_Dout = 8'h99; 8'hef: o_Dout = 8'h61;
      8'hf0: o_Dout = 8'h17; 8'hf1: o_Dout = 8'h2b; 8'hf2: o_Dout = 8'h04; 8'hf3: o_Dout = 8'h7e; 8'hf4: o_Dout = 8'hba; 8'hf5: o_Dout = 8'h77; 8'hf6: o_Dout = 8'hd6; 8'hf7: o_Dout = 8'h26;
      8'hf8: o_Dout = 8'he1; 8'hf9: o_Dout = 8'h69; 8'hfa: o_Dout = 8'h14; 8'hfb: o_Dout = 8'h63; 8'hfc: o_Dout = 8'h55; 8'hfd: o_Dout = 8'h21; 8'hfe: o_Dout = 8'h0c; 8'hff: o_Dout = 8'h7d;
      default: o_Dout = 8'h00;
    endcase
  end

endmodule

// File: rtl/sub_bytes_dec_iter.sv
// Iterative AES InvSubBytes: LANES shared inverse S-boxes sweep the 16 bytes in ascending order.
// Latency: 16/LANES cycles from accept to o_Valid; one block per 16/LANES+1 cycles back-to-back.
// Backpressure: o_Ready low while busy or while a finished block waits on i_Ready; o_Dout held stable.
// Ports: i_Clk/i_Rst_n clock and async active-low reset; i_Valid/o_Ready/i_Din upstream block;
//        o_Valid/i_Ready/o_Dout downstream block; o_Busy high while substituting.
module sub_bytes_dec_iter
  import aes_dec_pkg::*;
#(
  parameter int LANES = 4   // 1, 2, 4, 8 or 16
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_n,
  input  logic                 i_Valid,
  output logic                 o_Ready,
  input  logic [AES_BLK_W-1:0] i_Din,
  output logic                 o_Valid,
  input  logic                 i_Ready,
  output logic [AES_BLK_W-1:0] o_Dout,
  output logic                 o_Busy
);

  localparam int NCYC  = AES_NBYTES / LANES;
  localparam int CNT_W = cnt_width(NCYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCYC - 1);

  dec_st_e st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Byte-addressed view of the state: element k is bits [8k+7:8k].
  logic [AES_NBYTES-1:0][AES_BYTE_W-1:0] data_q, data_d;

  logic [LANES-1:0][AES_BYTE_W-1:0] sbox_in;
  logic [LANES-1:0][AES_BYTE_W-1:0] sbox_out;

  // Byte-select mux: lane l looks at byte cnt*LANES + l of the current state.
  always_comb begin
    logic [AES_IDX_W-1:0] idx;
    idx     = '0;
    sbox_in = '0;
    for (int l = 0; l < LANES; l++) begin
      idx        = AES_IDX_W'(int'(cnt_q) * LANES + l);
      sbox_in[l] = data_q[idx];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    inv_sbox u_inv_sbox (
      .i_Din  (sbox_in[l]),
      .o_Dout (sbox_out[l])
    );
  end

  // Next-state, counter and write-back demux.
  always_comb begin
    logic [AES_IDX_W-1:0] widx;
    st_d   = st_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    widx   = '0;
    case (st_q)
      ST_IDLE: begin
        if (i_Valid) begin
          data_d = i_Din;
          cnt_d  = '0;
          st_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        for (int l = 0; l < LANES; l++) begin
          widx         = AES_IDX_W'(int'(cnt_q) * LANES + l);
          data_d[widx] = sbox_out[l];
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          st_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        // Output and input handshakes can complete on the same edge.
        if (i_Ready) begin
          if (i_Valid) begin
            data_d = i_Din;
            cnt_d  = '0;
            st_d   = ST_BUSY;
          end else begin
            st_d = ST_IDLE;
          end
        end
      end
      default: begin
        st_d  = ST_IDLE;
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      st_q   <= ST_IDLE;
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
    end
  end

  assign o_Valid = (st_q == ST_DONE);
  assign o_Busy  = (st_q == ST_BUSY);
  assign o_Dout  = data_q;
  // Only combinational input-to-output path: i_Ready passes through while a block is waiting.
  assign o_Ready = (st_q == ST_IDLE) | ((st_q == ST_DONE) & i_Ready);

endmodule

// File: tb/tb_sub_bytes_dec_iter.sv
module tb_sub_bytes_dec_iter;

  typedef struct {
    logic [127:0] d;
    int           acc;
  } exp_t;

  logic clk;
  int   cyc;
  int   checks;
  int   errors;
  bit   done_a [3];
  logic [7:0] inv_tab [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference inverse S-box built from GF(2^8) arithmetic and the forward affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b  = b >> 1;
    end
    return p;
  endfunction

  initial begin
    logic [7:0] xb, inv, s;
    for (int x = 0; x < 256; x++) begin
      xb  = x[7:0];
      inv = 8'h00;
      if (xb != 8'h00) begin
        for (int y = 1; y < 256; y++) begin
          if (gmul(xb, y[7:0]) == 8'h01) inv = y[7:0];
        end
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      inv_tab[s] = xb;
    end
  end

  function automatic logic [127:0] inv_blk(input logic [127:0] d);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = inv_tab[d[8*k +: 8]];
    return r;
  endfunction

  task automatic chk(input int lanes, input string nm, input logic [127:0] act,
                     input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s lanes=%0d got=%h want=%h", nm, lanes, act, req);
    end
  endtask

  task automatic fail_now(input int lanes, input string nm);
    checks++;
    errors++;
    $display("FAIL %s lanes=%0d", nm, lanes);
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    localparam int L  = (gi == 0) ? 4 : ((gi == 1) ? 1 : 16);
    localparam int NL = 16 / L;

    logic         rst_n, vld_i, rdy_o, rdy_i, vld_o, busy_o;
    logic [127:0] din, dout;
    exp_t         q[$];
    bit           seen;

    sub_bytes_dec_iter #(.LANES(L)) dut (
      .i_Clk   (clk),
      .i_Rst_n (rst_n),
      .i_Valid (vld_i),
      .o_Ready (rdy_o),
      .i_Din   (din),
      .o_Valid (vld_o),
      .i_Ready (rdy_i),
      .o_Dout  (dout),
      .o_Busy  (busy_o)
    );

    // Monitor: every cycle with o_Valid compares against the head entry, so a
    // stalled output is re-checked each cycle; the head is retired on handshake.
    always @(negedge clk) begin
      if (rst_n && vld_o) begin
        if (q.size() == 0) begin
          fail_now(L, "unexpected_output");
        end else begin
          chk(L, "dout", dout, q[0].d);
          if (!seen) begin
            chk(L, "latency", 128'(cyc - q[0].acc), 128'(NL));
            seen = 1'b1;
          end
          if (rdy_i) begin
            void'(q.pop_front());
            seen = 1'b0;
          end
        end
      end
    end

    // All stimulus tasks start and end at posedge+1.
    task automatic send(input logic [127:0] d, input logic [127:0] e, input bit hold);
      bit ok;
      ok    = 1'b0;
      vld_i = 1'b1;
      din   = d;
      for (int n = 0; n < 200; n++) begin
        @(negedge clk);
        if (rdy_o) begin
          q.push_back('{d: e, acc: cyc + 1});
          ok = 1'b1;
          break;
        end
      end
      if (!ok) fail_now(L, "accept_timeout");
      @(posedge clk);
      #1;
      if (!hold) vld_i = 1'b0;
    endtask

    task automatic drain();
      for (int n = 0; n < 400; n++) begin
        if (q.size() == 0) break;
        @(posedge clk);
        #1;
      end
      if (q.size() != 0) fail_now(L, "drain_timeout");
      repeat (2) begin
        @(posedge clk);
        #1;
      end
    endtask

    task automatic reset_check(input string nm);
      chk(L, {nm, "_valid"}, 128'(vld_o), 128'(0));
      chk(L, {nm, "_busy"},  128'(busy_o), 128'(0));
      chk(L, {nm, "_ready"}, 128'(rdy_o), 128'(1));
      chk(L, {nm, "_dout"},  dout, 128'(0));
    endtask

    initial begin
      logic [127:0] blk, mix_in, mix_req;
      int nb;
      rst_n = 1'b1;
      vld_i = 1'b0;
      rdy_i = 1'b1;
      din   = '0;
      seen  = 1'b0;

      // Asynchronous reset, asserted between clock edges.
      #13;
      rst_n = 1'b0;
      #1;
      reset_check("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Uniform blocks.
      send({16{8'h63}}, 128'h0, 1'b0);
      drain();
      send(128'h0, {16{8'h52}}, 1'b0);
      drain();

      // Mixed bytes, plus BUSY duration.
      mix_in  = {96'h0, 8'hFF, 8'h7C, 8'h63, 8'h00};
      mix_req = {{12{8'h52}}, 8'h7D, 8'h01, 8'h00, 8'h52};
      send(mix_in, mix_req, 1'b0);
      nb = 0;
      for (int n = 0; n < 100; n++) begin
        if (vld_o) break;
        if (busy_o) nb++;
        @(posedge clk);
        #1;
      end
      chk(L, "busy_cycles", 128'(nb), 128'(NL));
      drain();

      // Backpressure: output must hold for 10 cycles, then transfer once.
      rdy_i = 1'b0;
      blk   = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
      send(blk, inv_blk(blk), 1'b0);
      for (int n = 0; n < 100; n++) begin
        if (vld_o) break;
        @(posedge clk);
        #1;
      end
      for (int n = 0; n < 10; n++) begin
        @(negedge clk);
        chk(L, "ready_stalled", 128'(rdy_o), 128'(0));
      end
      @(posedge clk);
      #1;
      rdy_i = 1'b1;
      drain();

      // Back-to-back with i_Valid held high.
      send(128'h000102030405060708090a0b0c0d0e0f, inv_blk(128'h000102030405060708090a0b0c0d0e0f), 1'b1);
      send(128'hdeadbeef0123456789abcdeffedcba98, inv_blk(128'hdeadbeef0123456789abcdeffedcba98), 1'b1);
      send(128'h8899aabbccddeeff0011223344556677, inv_blk(128'h8899aabbccddeeff0011223344556677), 1'b0);
      drain();

      // Every byte value once, streamed back-to-back.
      for (int b = 0; b < 16; b++) begin
        for (int k = 0; k < 16; k++) blk[8*k +: 8] = 8'(16 * b + k);
        send(blk, inv_blk(blk), b != 15);
      end
      drain();

      // Reset partway through BUSY discards the block.
      send({16{8'hA5}}, inv_blk({16{8'hA5}}), 1'b0);
      if (NL > 2) begin
        repeat (2) @(posedge clk);
      end
      #2;
      rst_n = 1'b0;
      q.delete();
      seen = 1'b0;
      #1;
      reset_check("reset_busy");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      send({16{8'h63}}, 128'h0, 1'b0);
      drain();

      done_a[gi] = 1'b1;
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    for (int n = 0; n < 20000; n++) begin
      if (done_a[0] && done_a[1] && done_a[2]) break;
      @(posedge clk);
    end
    if (!(done_a[0] && done_a[1] && done_a[2])) begin
      checks++;
      errors++;
      $display("FAIL global_timeout done=%0d%0d%0d", done_a[0], done_a[1], done_a[2]);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
